systolic_result_collector: RTL
==============================

SYSTOLIC_RESULT_COLLECTOR -- requirements
Module: systolic_result_collector

Interface
REQ-001 SHALL have parameter DW, default 16, meaning the data width of each array output and each output lane.
REQ-002 SHALL have parameter N, default 4, meaning the number of array columns; this revision supports only 4.
REQ-003 SHALL have parameter DEPTH, default 4, meaning the entries per column buffer.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-006 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-007 SHALL have port start, input, 1 bit: arms collection of one result matrix.
REQ-008 SHALL have port cfg_rows, input, 4 bits: rows expected (1..15), latched at start.
REQ-009 SHALL have ports sys_data_out_41..44, input, DW bits each: bottom-row array data, columns 1..4.
REQ-010 SHALL have ports sys_valid_out_41..44, input, 1 bit each: per-column valid, skewed +1 cycle per column.
REQ-011 SHALL have ports out_data_1..4, output, DW bits each: deskewed result row.
REQ-012 SHALL have port out_row_idx, output, 4 bits: index of the presented row, 0-based.
REQ-013 SHALL have port out_valid, output, 1 bit: the presented row is complete.
REQ-014 SHALL have port out_ready, input, 1 bit: downstream accepts; a transfer occurs when out_valid and out_ready are both high.
REQ-015 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-016 SHALL have port done, output, 1 bit: one-cycle pulse after the last row transfers.
REQ-017 SHALL have port overflow_err, output, 1 bit: sticky; set when a column write is dropped.

Function
REQ-018 SHALL implement states IDLE, COLLECT and DONE: IDLE->COLLECT on start; COLLECT->DONE on the transfer of row cfg_rows-1; DONE->IDLE unconditionally.
REQ-019 SHALL latch cfg_rows, clear row counters, and clear overflow_err on the IDLE->COLLECT edge.
REQ-020 SHALL ignore start outside IDLE.
REQ-021 SHALL ignore column valids in IDLE and DONE; nothing is written and no error is raised.
REQ-022 SHALL, in COLLECT, write column j's data at its write pointer whenever sys_valid_out_4j is high; columns are independent, so skew between columns is arbitrary.
REQ-023 SHALL accept a column write when the column count is below DEPTH, or when a row pop occurs in the same cycle.
REQ-024 SHALL otherwise drop the write and set overflow_err; the count and pointer are unchanged.
REQ-025 SHALL drive out_valid only in COLLECT and only when all 4 column counts are at least 1, using show-ahead from the head entries.
REQ-026 SHALL have latency of one cycle: if the last column element of a row is captured at edge t, out_valid is high in the cycle after edge t.
REQ-027 SHALL, on a transfer, pop all 4 columns, increment out_row_idx, and leave out_data stable while out_valid is high and out_ready is low.
REQ-028 SHALL keep a column's count unchanged on a simultaneous write and pop; pointers wrap modulo DEPTH.
REQ-029 SHALL count valids per column and ignore (without error) any write beyond cfg_rows for that column.
REQ-030 SHALL assert done in the DONE state only; busy SHALL be low only in IDLE.
REQ-031 SHALL drive out_data to 0 when out_valid is low.

Reset
REQ-032 SHALL, on rst high at a clock edge, go to IDLE and zero all pointers, counts, out_row_idx and the latched cfg_rows; out_valid, busy, done and overflow_err SHALL read 0 in the following cycle.
REQ-033 SHALL, on reset mid-COLLECT, discard all buffered data; no row is presented afterwards.

Structure
REQ-034 SHALL place the state enum and the DW/N defaults in shared package systolic_pkg.
REQ-035 SHALL instantiate one sub-module, sys_col_fifo (DEPTH-entry ring buffer with count, full and empty), once per column.
REQ-036 SHALL keep the FSM, row counters, deskew/pop logic and error flag in the top level.

Verification
REQ-037 SHALL cover: cfg_rows=4, out_ready=1, column j valid in cycles j..j+3 with data 10*r+j -> rows (1,2,3,4), (11,12,13,14), (21,..), (31,..) with idx 0..3, then done pulses once.
REQ-038 SHALL cover: same stimulus with out_ready=0 until all columns have 4 entries -> out_valid high with row 0 held stable and overflow_err=0; then rows 0..3 drain in order.
REQ-039 SHALL cover: out_ready=0 and a 5th valid on column 1 -> overflow_err=1 and rows 0..3 intact.
REQ-040 SHALL cover: cfg_rows=2 with 3 valids per column -> 2 rows out, done pulses, no error, and the extra write is ignored.
REQ-041 SHALL cover: rst asserted after 2 rows are buffered -> next cycle busy=0 and out_valid=0; a new start collects cleanly from idx 0.
REQ-042 SHALL cover: start asserted in COLLECT, and valids in IDLE -> no state change and no writes.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic result collector.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package systolic_pkg;

    localparam int DW_DEF = 16;
    localparam int N_DEF  = 4;
    localparam int ROW_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

endpackage

// File: rtl/sys_col_fifo.sv
// Per-column ring buffer with show-ahead head, occupancy count, full and empty flags.
// Latency: a write is visible at the head in the cycle after its capturing edge.
// Backpressure: writes while full are dropped unless a read happens in the same cycle.
module sys_col_fifo #(
    parameter int DW    = 16,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [DW-1:0]                wr_dat,
    input  logic                         rd_en,
    output logic [DW-1:0]                rd_dat,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_wr, do_rd;

    assign full   = (cnt_q == CNT_FULL);
    assign empty  = (cnt_q == '0);
    assign count  = cnt_q;
    assign rd_dat = mem_q[rd_ptr_q];
    assign do_rd  = rd_en & ~empty;
    assign do_wr  = wr_en & (~full | do_rd);

    // Next-state for storage, wrapping pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_wr) begin
            mem_d[wr_ptr_q] = wr_dat;
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
        end
        if (do_rd) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
        end
        case ({do_wr, do_rd})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Register update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/systolic_result_collector.sv
// Deskews the bottom-row outputs of a 4-column systolic array into whole result rows.
// Latency: a row is presented the cycle after its last column element is captured.
// Backpressure: valid/ready on the row; column writes beyond buffer space are dropped and flagged.
module systolic_result_collector
    import systolic_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int N     = N_DEF,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       cfg_rows,
    input  logic [DW-1:0]    sys_data_out_41,
    input  logic [DW-1:0]    sys_data_out_42,
    input  logic [DW-1:0]    sys_data_out_43,
    input  logic [DW-1:0]    sys_data_out_44,
    input  logic             sys_valid_out_41,
    input  logic             sys_valid_out_42,
    input  logic             sys_valid_out_43,
    input  logic             sys_valid_out_44,
    output logic [DW-1:0]    out_data_1,
    output logic [DW-1:0]    out_data_2,
    output logic [DW-1:0]    out_data_3,
    output logic [DW-1:0]    out_data_4,
    output logic [3:0]       out_row_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic             overflow_err
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    state_e          state_q, state_d;
    logic [3:0]      rows_q, rows_d;
    logic [3:0]      row_idx_q, row_idx_d;
    logic [3:0]      wr_cnt_q [N];
    logic [3:0]      wr_cnt_d [N];
    logic            ovf_q, ovf_d;

    logic [N-1:0]    col_vld, wr_req, col_wr, col_drop, col_full, col_empty;
    logic [DW-1:0]   col_wdat [N];
    logic [DW-1:0]   col_head [N];
    logic [CW-1:0]   col_cnt  [N];
    logic            in_collect, row_vld, row_pop, last_row;

    // Gather the per-column array outputs into indexable form.
    always_comb begin
        col_vld     = {sys_valid_out_44, sys_valid_out_43, sys_valid_out_42, sys_valid_out_41};
        col_wdat[0] = sys_data_out_41;
        col_wdat[1] = sys_data_out_42;
        col_wdat[2] = sys_data_out_43;
        col_wdat[3] = sys_data_out_44;
    end

    assign in_collect = (state_q == ST_COLLECT);
    assign row_vld    = in_collect & ~(|col_empty);
    assign row_pop    = row_vld & out_ready;
    assign last_row   = row_pop & (row_idx_q == rows_q - 4'd1);

    // Column write admission: only the first cfg_rows valids count, and a full column
    // still takes a write when the row pop frees its head in the same cycle.
    always_comb begin
        wr_req   = '0;
        col_wr   = '0;
        col_drop = '0;
        for (int j = 0; j < N; j++) begin
            wr_req[j]   = in_collect & col_vld[j] & (wr_cnt_q[j] < rows_q);
            col_wr[j]   = wr_req[j] & ((col_cnt[j] < DEPTH_C) | row_pop);
            col_drop[j] = wr_req[j] & col_full[j] & ~row_pop;
        end
    end

    // FSM next-state plus row/column counters and the sticky drop flag.
    always_comb begin
        state_d   = state_q;
        rows_d    = rows_q;
        row_idx_d = row_idx_q;
        wr_cnt_d  = wr_cnt_q;
        ovf_d     = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_COLLECT;
                    rows_d    = cfg_rows;
                    row_idx_d = '0;
                    ovf_d     = 1'b0;
                    for (int j = 0; j < N; j++) wr_cnt_d[j] = '0;
                end
            end
            ST_COLLECT: begin
                for (int j = 0; j < N; j++) begin
                    if (wr_req[j]) wr_cnt_d[j] = wr_cnt_q[j] + 4'd1;
                end
                if (|col_drop) ovf_d = 1'b1;
                if (row_pop) row_idx_d = row_idx_q + 4'd1;
                if (last_row) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rows_q    <= '0;
            row_idx_q <= '0;
            ovf_q     <= 1'b0;
            for (int j = 0; j < N; j++) wr_cnt_q[j] <= '0;
        end else begin
            state_q   <= state_d;
            rows_q    <= rows_d;
            row_idx_q <= row_idx_d;
            ovf_q     <= ovf_d;
            wr_cnt_q  <= wr_cnt_d;
        end
    end

    for (genvar j = 0; j < N; j++) begin : g_col
        sys_col_fifo #(
            .DW    (DW),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk    (clk),
            .rst    (rst),
            .wr_en  (col_wr[j]),
            .wr_dat (col_wdat[j]),
            .rd_en  (row_pop),
            .rd_dat (col_head[j]),
            .count  (col_cnt[j]),
            .full   (col_full[j]),
            .empty  (col_empty[j])
        );
    end

    assign out_valid    = row_vld;
    assign out_data_1   = row_vld ? col_head[0] : '0;
    assign out_data_2   = row_vld ? col_head[1] : '0;
    assign out_data_3   = row_vld ? col_head[2] : '0;
    assign out_data_4   = row_vld ? col_head[3] : '0;
    assign out_row_idx  = row_idx_q;
    assign busy         = (state_q != ST_IDLE);
    assign done         = (state_q == ST_DONE);
    assign overflow_err = ovf_q;

endmodule
